// File: rtl/apb5_completer_pkg.sv
// Shared types and constants for the APB5 completer register block.
// Optional feature macro: APB5_COMPLETER_USER_EN (PWUSER/PRUSER user fields).
package apb5_completer_pkg;

    // Transfer FSM states
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Width of the wait-state down-counter (WAIT_STATES range 0..15)
    localparam int WAIT_CNT_W = 4;

    // Index of the read-only ID register
    localparam int ID_IDX = 0;

endpackage : apb5_completer_pkg

// File: rtl/apb5_completer_regfile.sv
// Register storage for the APB5 completer: per-byte write enables, one
// combinational read port and a read-only ID register at index 0.
// Optional feature macro: APB5_COMPLETER_USER_EN adds a per-register user field.
module apb5_completer_regfile
    import apb5_completer_pkg::*;
#(
    parameter int          DATA_WIDTH      = 32,
    parameter int          NUM_REGS        = 8,
    parameter logic [31:0] ID_VALUE        = 32'hA5B5_0001,
    parameter int          USER_DATA_WIDTH = 16,
    parameter int          IDX_W           = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
`ifdef APB5_COMPLETER_USER_EN
    input  logic [USER_DATA_WIDTH-1:0] wuser,
    output logic [USER_DATA_WIDTH-1:0] ruser,
`endif
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NUM_LANES = DATA_WIDTH / 8;

    // Writable registers only; index 0 is the constant ID and has no storage.
    logic [DATA_WIDTH-1:0] regs_r [1:NUM_REGS-1];

    // Byte-lane register writes; the ID index is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs_r[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (we && (widx == IDX_W'(r))) begin
                    for (int b = 0; b < NUM_LANES; b++) begin
                        if (wstrb[b]) begin
                            regs_r[r][b*8 +: 8] <= wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read port: ID constant at index 0, zero for indices beyond the file.
    always_comb begin
        rdata = '0;
        if (ridx == IDX_W'(ID_IDX)) begin
            rdata = ID_VALUE[DATA_WIDTH-1:0];
        end else if (int'(ridx) < NUM_REGS) begin
            rdata = regs_r[ridx];
        end else begin
            rdata = '0;
        end
    end

`ifdef APB5_COMPLETER_USER_EN
    logic [USER_DATA_WIDTH-1:0] user_r [1:NUM_REGS-1];

    // User field is written whole on every committed write, ignoring strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                user_r[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (we && (widx == IDX_W'(r))) begin
                    user_r[r] <= wuser;
                end
            end
        end
    end

    // User read port; the ID register carries no user data.
    always_comb begin
        ruser = '0;
        if (ridx == IDX_W'(ID_IDX)) begin
            ruser = '0;
        end else if (int'(ridx) < NUM_REGS) begin
            ruser = user_r[ridx];
        end else begin
            ruser = '0;
        end
    end
`endif

endmodule : apb5_completer_regfile

// File: rtl/apb5_completer_regs.sv
// APB5 completer with a small register file, fixed wait states, PSLVERR on
// illegal accesses and a sticky protocol-violation flag.
// Optional feature macro: APB5_COMPLETER_USER_EN (PWUSER/PRUSER ports).
module apb5_completer_regs
    import apb5_completer_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 32,
    parameter int          DATA_WIDTH      = 32,
    parameter int          NUM_REGS        = 8,
    parameter logic [31:0] ID_VALUE        = 32'hA5B5_0001,
    parameter int          WAIT_STATES     = 0,
    parameter int          USER_DATA_WIDTH = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR,
`ifdef APB5_COMPLETER_USER_EN
    input  logic [USER_DATA_WIDTH-1:0] PWUSER,
    output logic [USER_DATA_WIDTH-1:0] PRUSER,
`endif
    output logic                    proto_err
);

    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(32'd1);

    state_e                  state_r;
    logic [WAIT_CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic                    write_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH/8-1:0] strb_r;
    logic [2:0]              pprot_r;
    logic                    err_r;
    logic [DATA_WIDTH-1:0]   rdata_cap_r;
    logic                    pready_r;
    logic [DATA_WIDTH-1:0]   prdata_r;
    logic                    pslverr_r;
    logic                    proto_err_r;

    logic [ADDR_WIDTH-1:0]   addr_idx_s;
    logic [IDX_W-1:0]        ridx_s;
    logic                    err_s;
    logic                    we_s;
    logic [DATA_WIDTH-1:0]   rf_rdata_s;
    logic [DATA_WIDTH-1:0]   rd_sel_s;

`ifdef APB5_COMPLETER_USER_EN
    logic [USER_DATA_WIDTH-1:0] wuser_r;
    logic [USER_DATA_WIDTH-1:0] ruser_cap_r;
    logic [USER_DATA_WIDTH-1:0] pruser_r;
    logic [USER_DATA_WIDTH-1:0] rf_ruser_s;
    logic [USER_DATA_WIDTH-1:0] ru_sel_s;
`endif

    // Decode the setup-cycle address into a register index and error flag.
    always_comb begin
        addr_idx_s = PADDR >> ADDR_LSB;
        ridx_s     = addr_idx_s[IDX_W-1:0];
        err_s      = 1'b0;
        if (addr_idx_s >= ADDR_WIDTH'(NUM_REGS)) begin
            err_s = 1'b1;
        end else if (PWRITE && (addr_idx_s == ADDR_WIDTH'(ID_IDX))) begin
            err_s = 1'b1;
        end else if (!PWRITE && (PSTRB != '0)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Read data presented on completion: zero for writes and errored reads.
    always_comb begin
        rd_sel_s = '0;
        if (PWRITE || err_s) begin
            rd_sel_s = '0;
        end else begin
            rd_sel_s = rf_rdata_s;
        end
    end

`ifdef APB5_COMPLETER_USER_EN
    // User data presented on completion: only for successful reads.
    always_comb begin
        ru_sel_s = '0;
        if (PWRITE || err_s) begin
            ru_sel_s = '0;
        end else begin
            ru_sel_s = rf_ruser_s;
        end
    end
`endif

    // Commit the captured write on the completing edge of an error-free write.
    always_comb begin
        we_s = 1'b0;
        if ((state_r == ACCESS) && PSEL && PENABLE && (cnt_r == '0)
            && write_r && !err_r) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Transfer FSM: setup capture, wait countdown, completion and abort.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            idx_r       <= '0;
            write_r     <= 1'b0;
            wdata_r     <= '0;
            strb_r      <= '0;
            pprot_r     <= 3'b000;
            err_r       <= 1'b0;
            rdata_cap_r <= '0;
            pready_r    <= 1'b0;
            prdata_r    <= '0;
            pslverr_r   <= 1'b0;
            proto_err_r <= 1'b0;
`ifdef APB5_COMPLETER_USER_EN
            wuser_r     <= '0;
            ruser_cap_r <= '0;
            pruser_r    <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    pready_r  <= 1'b0;
                    prdata_r  <= '0;
                    pslverr_r <= 1'b0;
`ifdef APB5_COMPLETER_USER_EN
                    pruser_r  <= '0;
`endif
                    if (PSEL && !PENABLE) begin
                        state_r     <= ACCESS;
                        cnt_r       <= WAIT_INIT;
                        idx_r       <= ridx_s;
                        write_r     <= PWRITE;
                        wdata_r     <= PWDATA;
                        strb_r      <= PSTRB;
                        pprot_r     <= PPROT;
                        err_r       <= err_s;
                        rdata_cap_r <= rd_sel_s;
`ifdef APB5_COMPLETER_USER_EN
                        wuser_r     <= PWUSER;
                        ruser_cap_r <= ru_sel_s;
`endif
                        // With no wait states the first access cycle completes.
                        if (WAIT_INIT == '0) begin
                            pready_r  <= 1'b1;
                            prdata_r  <= rd_sel_s;
                            pslverr_r <= err_s;
`ifdef APB5_COMPLETER_USER_EN
                            pruser_r  <= ru_sel_s;
`endif
                        end
                    end else if (PSEL && PENABLE) begin
                        // Access phase without a setup phase: ignored, flagged.
                        proto_err_r <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!PSEL || !PENABLE) begin
                        // Requester left the access phase early: drop transfer.
                        state_r     <= IDLE;
                        pready_r    <= 1'b0;
                        prdata_r    <= '0;
                        pslverr_r   <= 1'b0;
                        proto_err_r <= 1'b1;
`ifdef APB5_COMPLETER_USER_EN
                        pruser_r    <= '0;
`endif
                    end else if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            pready_r  <= 1'b1;
                            prdata_r  <= rdata_cap_r;
                            pslverr_r <= err_r;
`ifdef APB5_COMPLETER_USER_EN
                            pruser_r  <= ruser_cap_r;
`endif
                        end
                    end else begin
                        state_r   <= IDLE;
                        pready_r  <= 1'b0;
                        prdata_r  <= '0;
                        pslverr_r <= 1'b0;
`ifdef APB5_COMPLETER_USER_EN
                        pruser_r  <= '0;
`endif
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    pready_r  <= 1'b0;
                    prdata_r  <= '0;
                    pslverr_r <= 1'b0;
`ifdef APB5_COMPLETER_USER_EN
                    pruser_r  <= '0;
`endif
                end
            endcase
        end
    end

    apb5_completer_regfile #(
        .DATA_WIDTH      (DATA_WIDTH),
        .NUM_REGS        (NUM_REGS),
        .ID_VALUE        (ID_VALUE),
        .USER_DATA_WIDTH (USER_DATA_WIDTH),
        .IDX_W           (IDX_W)
    ) u_regfile (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (we_s),
        .widx  (idx_r),
        .wdata (wdata_r),
        .wstrb (strb_r),
`ifdef APB5_COMPLETER_USER_EN
        .wuser (wuser_r),
        .ruser (rf_ruser_s),
`endif
        .ridx  (ridx_s),
        .rdata (rf_rdata_s)
    );

    assign PREADY    = pready_r;
    assign PRDATA    = prdata_r;
    assign PSLVERR   = pslverr_r;
    assign proto_err = proto_err_r;
`ifdef APB5_COMPLETER_USER_EN
    assign PRUSER    = pruser_r;
`endif

endmodule : apb5_completer_regs
